alignment_s_32: RTL and testbench
=================================

// Module: alignment_s_32
// PURPOSE
//  Pre-add operand aligner for the single-precision add/sub path; feeds normalization_s_32.
//  Unpacks two IEEE-754 operands and orders them by magnitude.
//  Right-shifts the smaller significand by the exponent difference, iteratively, collecting guard/round/sticky.
//  Presents an aligned pair plus the common base exponent over a valid/ready handshake.
// PARAMETERS
//  SHIFT_STEP  1   max bits shifted right per SHIFT cycle (legal: 1,2,4,8)
//  MAX_SHIFT   26  exponent diff above which small operand collapses to sticky only
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous active-high reset
//  in_valid    in   1   operand pair valid
//  in_ready    out  1   aligner can accept (IDLE only)
//  a           in   32  operand A, IEEE-754 single
//  b           in   32  operand B, IEEE-754 single
//  out_valid   out  1   aligned result valid
//  out_ready   in   1   consumer accepts result
//  man_big     out  27  {hidden,frac[22:0],G,R,S} of larger-magnitude operand
//  man_small   out  27  same format, smaller operand, aligned to exp_base
//  exp_base    out  8   exponent of larger operand (passes to normalization)
//  sign_big    out  1   sign of larger operand
//  sign_small  out  1   sign of smaller operand
//  swapped     out  1   1 = B was larger (big=B)
//  special     out  1   either operand exp==8'hFF (inf/NaN); no shift applied
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready=1; out_valid=0; all data outputs 0. Reset mid-op aborts, no output.
//  FSM IDLE->(SHIFT|DONE)->IDLE. Accept = in_valid&in_ready at a rising edge.
//  Unpack: hidden=(exp!=0); effective exp = (exp==0)?1:exp; significand={hidden,frac,3'b000}.
//  Order: compare {exp,frac}; B strictly greater -> swapped=1, else A is big (ties: A big).
//  diff = eff_exp_big - eff_exp_small (8-bit, unsigned, never negative).
//  On accept: special or diff==0 -> DONE; diff>MAX_SHIFT -> man_small=27'h1 if small
//   significand nonzero else 0, ->DONE; else ->SHIFT with remaining=diff.
//  SHIFT: per cycle n=min(SHIFT_STEP,remaining); man_small>>=n; bits shifted out OR'd
//   into bit0 (sticky); remaining-=n; remaining==0 -> DONE.
//  Latency accept->out_valid: 1+ceil(diff/SHIFT_STEP) cycles; 1 cycle for diff==0,
//   diff>MAX_SHIFT, or special.
//  DONE: out_valid=1, outputs stable until out_ready=1; handshake edge -> IDLE
//   (in_ready=1 next cycle; no same-cycle re-accept). man_big never shifted.
//  in_ready=0 in SHIFT/DONE; in_valid ignored there. Inputs sampled only at accept.
// CONFIGURATION
//  ALIGN_GRS_EN defined: G/R/S bits computed as above.
//  ALIGN_GRS_EN undefined: man_big[2:0]=man_small[2:0]=3'b000 always; shifted-out
//   bits discarded; diff>MAX_SHIFT gives man_small=0. Latency unchanged.
// TESTING (SHIFT_STEP=1, MAX_SHIFT=26, ALIGN_GRS_EN defined unless noted)
//  a=0x3F800000,b=0x3F800000 -> 1 cycle; man_big=man_small=27'h4000000, exp_base=8'h7F, swapped=0.
//  a=0x3F800000,b=0x40000000 -> 2 cycles; swapped=1, exp_base=8'h80, man_big=27'h4000000, man_small=27'h2000000.
//  a=0x4B800000,b=0x3F800001 -> 25 cycles; exp_base=8'h97, man_small=27'h5 (0x0 with GRS off).
//  a=0x7F000000,b=0x3F800000 -> diff 127, 1 cycle; man_small=27'h1, exp_base=8'hFE.
//  Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0; then release -> IDLE.
//  Assert rst 10 cycles into case 3 -> out_valid=0, in_ready=1 at once; case 2 rerun gives exact case-2 result.

Source files
------------

// File: rtl/alignment_s_32.sv
// Single-precision pre-add aligner: orders two operands by magnitude and shifts the smaller
// significand right to the larger exponent. Optional G/R/S tracking via `ALIGN_GRS_EN.
module alignment_s_32 #(
  parameter int unsigned SHIFT_STEP = 1,
  parameter int unsigned MAX_SHIFT  = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [26:0] man_big,
  output logic [26:0] man_small,
  output logic [7:0]  exp_base,
  output logic        sign_big,
  output logic        sign_small,
  output logic        swapped,
  output logic        special
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE, and the result
  // registers hold steady until out_ready completes the transfer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [26:0] man_big_q, man_big_d;
  logic [26:0] man_small_q, man_small_d;
  logic [7:0]  exp_base_q, exp_base_d;
  logic        sign_big_q, sign_big_d;
  logic        sign_small_q, sign_small_d;
  logic        swapped_q, swapped_d;
  logic        special_q, special_d;
  logic [7:0]  remaining_q, remaining_d;

  // Operand unpack
  logic [7:0]  exp_a, exp_b, eff_a, eff_b;
  logic        hid_a, hid_b;
  logic [26:0] sig_a, sig_b;
  logic        b_greater;
  logic [7:0]  eff_big, eff_small, diff;
  logic [26:0] sig_big, sig_small;
  logic        special_in;
  logic [26:0] collapse_val;

  always_comb begin
    exp_a      = a[30:23];
    exp_b      = b[30:23];
    hid_a      = (exp_a != 8'd0);
    hid_b      = (exp_b != 8'd0);
    eff_a      = hid_a ? exp_a : 8'd1;
    eff_b      = hid_b ? exp_b : 8'd1;
    sig_a      = {hid_a, a[22:0], 3'b000};
    sig_b      = {hid_b, b[22:0], 3'b000};
    // Magnitude order ignores sign; equal magnitudes keep A as the big operand.
    b_greater  = (b[30:0] > a[30:0]);
    eff_big    = b_greater ? eff_b : eff_a;
    eff_small  = b_greater ? eff_a : eff_b;
    sig_big    = b_greater ? sig_b : sig_a;
    sig_small  = b_greater ? sig_a : sig_b;
    diff       = eff_big - eff_small;
    special_in = (exp_a == 8'hFF) || (exp_b == 8'hFF);
`ifdef ALIGN_GRS_EN
    collapse_val = (sig_small != 27'd0) ? 27'h1 : 27'h0;
`else
    collapse_val = 27'h0;
`endif
  end

  // One shift step: move by min(SHIFT_STEP, remaining)
  logic [7:0]  step_n;
  logic [26:0] shifted;
  logic [26:0] step_result;
`ifdef ALIGN_GRS_EN
  logic [26:0] lost_mask;
  logic        lost;
`endif

  always_comb begin
    step_n  = (remaining_q < SHIFT_STEP[7:0]) ? remaining_q : SHIFT_STEP[7:0];
    shifted = man_small_q >> step_n;
`ifdef ALIGN_GRS_EN
    lost_mask   = (27'h1 << step_n) - 27'h1;
    lost        = |(man_small_q & lost_mask);
    step_result = {shifted[26:1], shifted[0] | lost};
`else
    step_result = {shifted[26:3], 3'b000};
`endif
  end

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    man_big_d    = man_big_q;
    man_small_d  = man_small_q;
    exp_base_d   = exp_base_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    swapped_d    = swapped_q;
    special_d    = special_q;
    remaining_d  = remaining_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          man_big_d    = sig_big;
          man_small_d  = sig_small;
          exp_base_d   = eff_big;
          sign_big_d   = b_greater ? b[31] : a[31];
          sign_small_d = b_greater ? a[31] : b[31];
          swapped_d    = b_greater;
          special_d    = special_in;
          remaining_d  = diff;
          in_ready_d   = 1'b0;
          if (special_in || (diff == 8'd0)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else if (diff > MAX_SHIFT[7:0]) begin
            // Everything would fall off the end: only sticky survives.
            man_small_d = collapse_val;
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        man_small_d = step_result;
        remaining_d = remaining_q - step_n;
        if (remaining_q == step_n) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      man_big_q    <= 27'd0;
      man_small_q  <= 27'd0;
      exp_base_q   <= 8'd0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      swapped_q    <= 1'b0;
      special_q    <= 1'b0;
      remaining_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      man_big_q    <= man_big_d;
      man_small_q  <= man_small_d;
      exp_base_q   <= exp_base_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      swapped_q    <= swapped_d;
      special_q    <= special_d;
      remaining_q  <= remaining_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign man_big    = man_big_q;
  assign man_small  = man_small_q;
  assign exp_base   = exp_base_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign swapped    = swapped_q;
  assign special    = special_q;

endmodule

// File: tb/tb_alignment_s_32.sv
// Directed bench for alignment_s_32 (SHIFT_STEP=1, MAX_SHIFT=26); expectations follow
// whether ALIGN_GRS_EN is defined for the build.
module tb_alignment_s_32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] man_big;
  logic [26:0] man_small;
  logic [7:0]  exp_base;
  logic        sign_big;
  logic        sign_small;
  logic        swapped;
  logic        special;

  int errors = 0;
  int checks = 0;

`ifdef ALIGN_GRS_EN
  localparam bit GRS = 1'b1;
`else
  localparam bit GRS = 1'b0;
`endif

  alignment_s_32 #(.SHIFT_STEP(1), .MAX_SHIFT(26)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .man_big(man_big), .man_small(man_small), .exp_base(exp_base),
    .sign_big(sign_big), .sign_small(sign_small),
    .swapped(swapped), .special(special)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers
  task automatic accept(input logic [31:0] av, input logic [31:0] bv);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait in_ready=%b required 1", in_ready);
    end
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hs in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
    checks++;
    if ({man_big, man_small, exp_base, sign_big, sign_small, swapped, special} !== 66'd0) begin
      errors++;
      $display("FAIL reset_data man_big=%h man_small=%h exp=%h required all 0", man_big, man_small, exp_base);
    end
  endtask

  task automatic test_equal();
    int lat;
    accept(32'h3F800000, 32'h3F800000);
    wait_out(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL eq_latency got %0d required 1", lat); end
    checks++;
    if ({man_big, man_small, exp_base, swapped} !== {27'h4000000, 27'h4000000, 8'h7F, 1'b0}) begin
      errors++;
      $display("FAIL eq_data mb=%h ms=%h e=%h sw=%b required 4000000 4000000 7f 0", man_big, man_small, exp_base, swapped);
    end
    release_out();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL eq_release in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_swap(input string tag);
    int lat;
    accept(32'h3F800000, 32'h40000000);
    wait_out(lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL %s_latency got %0d required 2", tag, lat); end
    checks++;
    if ({man_big, man_small, exp_base, swapped, special} !== {27'h4000000, 27'h2000000, 8'h80, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s_data mb=%h ms=%h e=%h sw=%b sp=%b required 4000000 2000000 80 1 0",
               tag, man_big, man_small, exp_base, swapped, special);
    end
    release_out();
  endtask

  task automatic test_sign();
    int lat;
    accept(32'hC0000000, 32'h3F800000);
    wait_out(lat);
    checks++;
    if ({lat[7:0], man_big, man_small, exp_base, sign_big, sign_small, swapped}
        !== {8'd2, 27'h4000000, 27'h2000000, 8'h80, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sign lat=%0d mb=%h ms=%h e=%h sb=%b ss=%b sw=%b required 2 4000000 2000000 80 1 0 0",
               lat, man_big, man_small, exp_base, sign_big, sign_small, swapped);
    end
    release_out();
  endtask

  // Long shift; in_valid held high with other data during SHIFT must be ignored.
  task automatic test_long_shift();
    int lat;
    logic [26:0] exp_ms;
    exp_ms = GRS ? 27'h5 : 27'h0;
    accept(32'h4B800000, 32'h3F800001);
    a = 32'h3F800000;
    b = 32'h3F800000;
    in_valid = 1'b1;
    checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL shift_busy in_ready,out_valid=%b required 00", {in_ready, out_valid});
    end
    wait_out(lat);
    in_valid = 1'b0;
    checks++;
    if (lat !== 25) begin errors++; $display("FAIL shift24_latency got %0d required 25", lat); end
    checks++;
    if ({man_big, man_small, exp_base, swapped} !== {27'h4000000, exp_ms, 8'h97, 1'b0}) begin
      errors++;
      $display("FAIL shift24_data mb=%h ms=%h e=%h sw=%b required 4000000 %h 97 0",
               man_big, man_small, exp_base, swapped, exp_ms);
    end
    release_out();
  endtask

  task automatic test_max_shift();
    int lat;
    logic [26:0] exp_ms;
    exp_ms = GRS ? 27'h1 : 27'h0;
    // diff == MAX_SHIFT still shifts
    accept(32'h4C800000, 32'h3F800001);
    wait_out(lat);
    checks++;
    if ({lat[7:0], man_small, exp_base} !== {8'd27, exp_ms, 8'h99}) begin
      errors++;
      $display("FAIL diff26 lat=%0d ms=%h e=%h required 27 %h 99", lat, man_small, exp_base, exp_ms);
    end
    release_out();
    // diff == MAX_SHIFT+1 collapses at once
    accept(32'h4D000000, 32'h3F800001);
    wait_out(lat);
    checks++;
    if ({lat[7:0], man_small, exp_base} !== {8'd1, exp_ms, 8'h9A}) begin
      errors++;
      $display("FAIL diff27 lat=%0d ms=%h e=%h required 1 %h 9a", lat, man_small, exp_base, exp_ms);
    end
    release_out();
    accept(32'h7F000000, 32'h3F800000);
    wait_out(lat);
    checks++;
    if ({lat[7:0], man_small, exp_base, swapped} !== {8'd1, exp_ms, 8'hFE, 1'b0}) begin
      errors++;
      $display("FAIL diff127 lat=%0d ms=%h e=%h sw=%b required 1 %h fe 0", lat, man_small, exp_base, swapped, exp_ms);
    end
    release_out();
  endtask

  task automatic test_special_denorm();
    int lat;
    accept(32'h7F800000, 32'h3F800000);
    wait_out(lat);
    checks++;
    if ({lat[7:0], special, man_big, man_small, exp_base} !== {8'd1, 1'b1, 27'h4000000, 27'h4000000, 8'hFF}) begin
      errors++;
      $display("FAIL special lat=%0d sp=%b mb=%h ms=%h e=%h required 1 1 4000000 4000000 ff",
               lat, special, man_big, man_small, exp_base);
    end
    release_out();
    accept(32'h00000001, 32'h00000000);
    wait_out(lat);
    checks++;
    if ({lat[7:0], special, man_big, man_small, exp_base, swapped} !== {8'd1, 1'b0, 27'h8, 27'h0, 8'h01, 1'b0}) begin
      errors++;
      $display("FAIL denorm lat=%0d sp=%b mb=%h ms=%h e=%h sw=%b required 1 0 8 0 01 0",
               lat, special, man_big, man_small, exp_base, swapped);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    bit stable;
    accept(32'h3F800000, 32'h40000000);
    wait_out(lat);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && man_big === 27'h4000000 &&
            man_small === 27'h2000000 && exp_base === 8'h80 && swapped === 1'b1))
        stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL hold ov=%b ir=%b mb=%h ms=%h e=%h required 1 0 4000000 2000000 80",
               out_valid, in_ready, man_big, man_small, exp_base);
    end
    release_out();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL hold_release in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid_op();
    accept(32'h4B800000, 32'h3F800001);
    repeat (9) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, man_small} !== {1'b1, 1'b0, 27'h0}) begin
      errors++;
      $display("FAIL midreset ir=%b ov=%b ms=%h required 1 0 0", in_ready, out_valid, man_small);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    test_swap("rerun");
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 32'h0;
    b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_equal();
    test_swap("swap");
    test_sign();
    test_long_shift();
    test_max_shift();
    test_special_denorm();
    test_backpressure();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
